key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/kbd_pkg.sv | 42 ++++
 rtl/key_repeat_timer.sv | 53 +++++
 rtl/key_event_decoder.sv | 158 +++++++++++++++
 tb/tb_key_event_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: prefix FSM states, PS/2 control bytes,
// the game key codes and the default channel table.
package kbd_pkg;

   // Prefix FSM states of the scan-code decoder
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } prefix_state_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_IGN_E1 = 8'hE1;
   localparam logic [7:0] PS2_IGN_AA = 8'hAA;

   // Key entries: bit 8 = E0-extended, bits 7:0 = scan code
   localparam logic [8:0] KEY_LEFT  = 9'h16B;
   localparam logic [8:0] KEY_RIGHT = 9'h174;
   localparam logic [8:0] KEY_UP    = 9'h175;
   localparam logic [8:0] KEY_DOWN  = 9'h172;
   localparam logic [8:0] KEY_P     = 9'h04D;
   localparam logic [8:0] KEY_R     = 9'h02D;
   localparam logic [8:0] KEY_SPACE = 9'h029;
   localparam logic [8:0] KEY_ESC   = 9'h076;

   localparam int PREFIX_TIMER_W = 26;

   // Channel 0 is the rightmost entry: ESC=0, SPACE=1, LEFT=2, RIGHT=3,
   // DOWN=4, UP=5, R=6, P=7
   localparam logic [71:0] KEY_CODES_DEFAULT = {KEY_P, KEY_R, KEY_UP, KEY_DOWN,
                                                KEY_RIGHT, KEY_LEFT, KEY_SPACE, KEY_ESC};

   // True when a table entry equals the decoded {ext, code} pair
   function automatic logic key_match(input logic [8:0] entry,
                                      input logic       ext,
                                      input logic [7:0] code);
      return entry == {ext, code};
   endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timing for the single tracked key: waits REPEAT_DELAY cycles
// after start, then fires every REPEAT_PERIOD cycles until cancelled.
// fire is a one-cycle request; the caller registers it into key_press.
module key_repeat_timer #(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic cancel,
   output logic fire
);

   localparam logic [25:0] DELAY_LAST  = 26'(REPEAT_DELAY - 1);
   localparam logic [25:0] PERIOD_LAST = 26'(REPEAT_PERIOD - 1);

   logic        active_r;
   logic        period_r;
   logic [25:0] cnt_r;
   logic        at_limit_s;

   // Detect end of the current delay/period phase; cancel suppresses firing
   always_comb begin
      at_limit_s = period_r ? (cnt_r == PERIOD_LAST) : (cnt_r == DELAY_LAST);
      fire       = active_r && !cancel && at_limit_s;
   end

   // Delay/period counter; cancel wins over start, start restarts the delay
   always_ff @(posedge clk) begin
      if (rst) begin
         active_r <= 1'b0;
         period_r <= 1'b0;
         cnt_r    <= 26'd0;
      end else if (cancel) begin
         active_r <= 1'b0;
         period_r <= 1'b0;
         cnt_r    <= 26'd0;
      end else if (start) begin
         active_r <= 1'b1;
         period_r <= 1'b0;
         cnt_r    <= 26'd0;
      end else if (active_r && at_limit_s) begin
         period_r <= 1'b1;
         cnt_r    <= 26'd0;
      end else if (active_r) begin
         cnt_r    <= cnt_r + 26'd1;
      end else begin
         cnt_r    <= 26'd0;
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 scan-byte decoder: tracks E0/F0 prefixes, matches terminal bytes
// against a table of key channels and produces held levels plus one-cycle
// press/release pulses. Optional feature macro KEY_AUTOREPEAT_EN adds
// auto-repeat press pulses for the most recently pressed key.
module key_event_decoder
   import kbd_pkg::*;
#(
   parameter int                    NUM_KEYS       = 8,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = KEY_CODES_DEFAULT,
   parameter int                    PREFIX_TIMEOUT = 50_000_000,
   parameter int                    REPEAT_DELAY   = 25_000_000,
   parameter int                    REPEAT_PERIOD  = 5_000_000
) (
   input  logic                CLK_50M,
   input  logic                RST,
   input  logic [7:0]          ps2_byte,
   input  logic                ps2_byte_vld,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                any_press
);

   localparam logic [PREFIX_TIMER_W-1:0] PFX_LAST = PREFIX_TIMER_W'(PREFIX_TIMEOUT - 1);

   // Reject configurations the counters cannot represent
   if (NUM_KEYS < 1 || NUM_KEYS > 32 || PREFIX_TIMEOUT < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("key_event_decoder: parameter out of range");
   end

   prefix_state_t               state_r;
   logic [PREFIX_TIMER_W-1:0]   pfx_timer_r;
   logic [NUM_KEYS-1:0]         key_held_r, key_press_r, key_release_r;
   logic                        any_press_r;

   logic                        in_ext_s, in_brk_s;
   logic                        is_ext_s, is_brk_s, is_ign_s;
   logic                        prefix_s, error_s, terminal_s;
   logic [NUM_KEYS-1:0]         match_s, press_s, release_s, rpt_vec_s;

   // Classify the incoming byte against the current prefix state
   always_comb begin
      in_ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
      in_brk_s   = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
      is_ext_s   = (ps2_byte == PS2_EXT);
      is_brk_s   = (ps2_byte == PS2_BRK);
      is_ign_s   = (ps2_byte == PS2_IGN_E1) || (ps2_byte == PS2_IGN_AA);
      prefix_s   = (is_ext_s && (state_r == ST_IDLE)) ||
                   (is_brk_s && ((state_r == ST_IDLE) || (state_r == ST_EXT)));
      error_s    = (is_ext_s && in_ext_s) || (is_brk_s && in_brk_s);
      // E0 while in BRK is neither prefix nor error, so it is decoded as a code
      terminal_s = ps2_byte_vld && !is_ign_s && !prefix_s && !error_s;
   end

   // Match the terminal byte against every channel; duplicates all respond
   always_comb begin
      match_s = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         match_s[i] = terminal_s && key_match(KEY_CODES[9*i +: 9], in_ext_s, ps2_byte);
      end
      press_s   = match_s & ~key_held_r & {NUM_KEYS{!in_brk_s}};
      release_s = match_s &  key_held_r & {NUM_KEYS{in_brk_s}};
   end

`ifdef KEY_AUTOREPEAT_EN
   logic [NUM_KEYS-1:0] rpt_sel_r;
   logic [NUM_KEYS-1:0] first_press_s;
   logic                found_s;
   logic                rpt_start_s, rpt_cancel_s, rpt_fire_s;

   // Pick the lowest pressed channel as repeat target and form repeat pulses
   always_comb begin
      found_s       = 1'b0;
      first_press_s = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         first_press_s[i] = press_s[i] && !found_s;
         found_s          = found_s || press_s[i];
      end
      rpt_start_s  = |press_s;
      rpt_cancel_s = |(release_s & rpt_sel_r);
      rpt_vec_s    = rpt_sel_r & {NUM_KEYS{rpt_fire_s}};
   end

   // Remember which channel currently owns auto-repeat
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         rpt_sel_r <= '0;
      end else if (rpt_start_s) begin
         rpt_sel_r <= first_press_s;
      end else begin
         rpt_sel_r <= rpt_sel_r;
      end
   end

   key_repeat_timer #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_repeat_timer (
      .clk    (CLK_50M),
      .rst    (RST),
      .start  (rpt_start_s),
      .cancel (rpt_cancel_s),
      .fire   (rpt_fire_s)
   );
`else
   // No auto-repeat: presses come only from decoded makes
   always_comb begin
      rpt_vec_s = '0;
   end
`endif

   // Prefix FSM, prefix timeout and registered key outputs
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         state_r       <= ST_IDLE;
         pfx_timer_r   <= '0;
         key_held_r    <= '0;
         key_press_r   <= '0;
         key_release_r <= '0;
         any_press_r   <= 1'b0;
      end else begin
         if (ps2_byte_vld) begin
            pfx_timer_r <= '0;
            if (is_ign_s) begin
               state_r <= state_r;
            end else if (prefix_s) begin
               case (state_r)
                  ST_IDLE: state_r <= is_ext_s ? ST_EXT : ST_BRK;
                  ST_EXT:  state_r <= ST_EXT_BRK;
                  default: state_r <= ST_IDLE;
               endcase
            end else begin
               state_r <= ST_IDLE;
            end
         end else if (state_r != ST_IDLE) begin
            if (pfx_timer_r == PFX_LAST) begin
               state_r     <= ST_IDLE;
               pfx_timer_r <= '0;
            end else begin
               pfx_timer_r <= pfx_timer_r + {{(PREFIX_TIMER_W-1){1'b0}}, 1'b1};
            end
         end else begin
            pfx_timer_r <= '0;
         end
         key_held_r    <= (key_held_r | press_s) & ~release_s;
         key_press_r   <= press_s | rpt_vec_s;
         key_release_r <= release_s;
         any_press_r   <= |(press_s | rpt_vec_s);
      end
   end

   assign key_held    = key_held_r;
   assign key_press   = key_press_r;
   assign key_release = key_release_r;
   assign any_press   = any_press_r;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios with constant expectations
// plus a randomized byte stream checked against a behavioural model.
module tb_key_event_decoder;

   localparam int NK = 8;
   localparam int PT = 40;
   localparam int RD = 100;
   localparam int RP = 20;
   localparam int CH_LEFT = 2, CH_RIGHT = 3, CH_DOWN = 4, CH_P = 7;

   logic          clk_50m = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    ps2_byte = 8'h00;
   logic          ps2_byte_vld = 1'b0;
   logic [NK-1:0] key_held, key_press, key_release;
   logic          any_press;

   int total = 0;
   int bad = 0;

   // Independent copy of the key table, channel 0 first
   logic [8:0] code_tab [NK] = '{9'h076, 9'h029, 9'h16B, 9'h174, 9'h172, 9'h175, 9'h02D, 9'h04D};
   logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h4D, 8'h2D, 8'h29, 8'h1C};

   // Reference model state
   logic [NK-1:0] held_m, exp_press, exp_release, exp_held;
   bit pend_ext, pend_brk;
   int idle_m, cyc_m;
`ifdef KEY_AUTOREPEAT_EN
   bit rpt_on;
   int rpt_ch, rpt_t0;
`endif

   key_event_decoder #(
      .NUM_KEYS(NK), .PREFIX_TIMEOUT(PT), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .CLK_50M(clk_50m), .RST(rst), .ps2_byte(ps2_byte), .ps2_byte_vld(ps2_byte_vld),
      .key_held(key_held), .key_press(key_press), .key_release(key_release),
      .any_press(any_press)
   );

   always #10 clk_50m = ~clk_50m;

   // Model of one clock cycle, written from the protocol rules
   task automatic model_cycle(input logic v, input logic [7:0] b);
      logic [NK-1:0] made;
      bit term, ext, brk;
      made = '0; exp_press = '0; exp_release = '0;
      term = 0; ext = 0; brk = 0;
      cyc_m++;
      if (rst) begin
         held_m = '0; pend_ext = 0; pend_brk = 0; idle_m = 0;
`ifdef KEY_AUTOREPEAT_EN
         rpt_on = 0;
`endif
      end else begin
         if (v) begin
            if (idle_m >= PT) begin pend_ext = 0; pend_brk = 0; end
            idle_m = 0;
            if (b == 8'hE1 || b == 8'hAA) begin
            end else if (b == 8'hE0 && !pend_ext && !pend_brk) begin
               pend_ext = 1;
            end else if (b == 8'hF0 && !pend_brk) begin
               pend_brk = 1;
            end else if ((b == 8'hE0 && pend_ext) || (b == 8'hF0 && pend_brk)) begin
               pend_ext = 0; pend_brk = 0;
            end else begin
               term = 1; ext = pend_ext; brk = pend_brk;
               pend_ext = 0; pend_brk = 0;
            end
         end else if (idle_m < PT) begin
            idle_m++;
         end
         if (term) begin
            for (int i = 0; i < NK; i++) begin
               if (code_tab[i] == {ext, b}) begin
                  if (brk && held_m[i]) exp_release[i] = 1'b1;
                  if (!brk && !held_m[i]) made[i] = 1'b1;
               end
            end
         end
         exp_press = made;
`ifdef KEY_AUTOREPEAT_EN
         if (rpt_on && exp_release[rpt_ch]) rpt_on = 0;
         if (rpt_on && (cyc_m - rpt_t0) >= RD && ((cyc_m - rpt_t0 - RD) % RP) == 0)
            exp_press[rpt_ch] = 1'b1;
         if (made != '0) begin
            rpt_on = 1; rpt_t0 = cyc_m;
            for (int i = NK - 1; i >= 0; i--) if (made[i]) rpt_ch = i;
         end
`endif
         held_m = (held_m | made) & ~exp_release;
      end
      exp_held = held_m;
   endtask

   // Drive one cycle of input at a falling edge, return at the next one
   task automatic tick(input logic v, input logic [7:0] b);
      ps2_byte_vld = v;
      ps2_byte     = b;
      @(negedge clk_50m);
      model_cycle(v, b);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b1, 8'hE0);
      rst = 1'b0;
      tick(1'b0, 8'h00);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(1'b1, 8'hE0);
      total++;
      if ({key_held, key_press, key_release, any_press} !== 25'd0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0", {key_held, key_press, key_release, any_press});
      end
      tick(1'b1, 8'h6B);
      rst = 1'b0;
      tick(1'b1, 8'h6B);
      total++;
      if (key_press !== 8'h00 || key_held !== 8'h00) begin
         bad++; $display("FAIL reset_strobe_ignored press=%h held=%h want=00", key_press, key_held);
      end
   endtask

   task automatic test_make_break();
      do_reset();
      tick(1'b1, 8'hE0);
      total++;
      if (key_press !== 8'h00) begin bad++; $display("FAIL mb_prefix_quiet got=%h want=00", key_press); end
      tick(1'b1, 8'h6B);
      total++;
      if (key_press !== 8'h04 || key_held !== 8'h04 || any_press !== 1'b1) begin
         bad++; $display("FAIL mb_make press=%h held=%h any=%b want 04/04/1", key_press, key_held, any_press);
      end
      tick(1'b0, 8'h00);
      total++;
      if (key_press !== 8'h00 || key_held !== 8'h04 || any_press !== 1'b0) begin
         bad++; $display("FAIL mb_pulse_width press=%h held=%h any=%b want 00/04/0", key_press, key_held, any_press);
      end
      tick(1'b1, 8'hE0); tick(1'b1, 8'hF0); tick(1'b1, 8'h6B);
      total++;
      if (key_release !== 8'h04 || key_held !== 8'h00 || key_press !== 8'h00) begin
         bad++; $display("FAIL mb_break rel=%h held=%h press=%h want 04/00/00", key_release, key_held, key_press);
      end
      tick(1'b0, 8'h00);
      total++;
      if (key_release !== 8'h00) begin bad++; $display("FAIL mb_release_width got=%h want=00", key_release); end
   endtask

   task automatic test_typematic();
      int np, nr;
      do_reset();
      np = 0;
      repeat (3) begin
         tick(1'b1, 8'h4D); np += int'(key_press[CH_P]);
         tick(1'b0, 8'h00); np += int'(key_press[CH_P]);
      end
      total++;
      if (np != 1 || key_held !== 8'h80) begin
         bad++; $display("FAIL typematic presses=%0d held=%h want 1/80", np, key_held);
      end
      nr = 0;
      tick(1'b1, 8'hF0); nr += int'(key_release[CH_P]);
      tick(1'b1, 8'h4D); nr += int'(key_release[CH_P]);
      tick(1'b0, 8'h00); nr += int'(key_release[CH_P]);
      total++;
      if (nr != 1 || key_held !== 8'h00) begin
         bad++; $display("FAIL typematic_release count=%0d held=%h want 1/00", nr, key_held);
      end
   endtask

   task automatic test_unmapped();
      do_reset();
      tick(1'b1, 8'h6B);
      total++;
      if ({key_held, key_press, key_release} !== 24'd0) begin
         bad++; $display("FAIL unext_6b got=%h want=0", {key_held, key_press, key_release});
      end
      tick(1'b1, 8'h1C);
      total++;
      if ({key_held, key_press, key_release, any_press} !== 25'd0) begin
         bad++; $display("FAIL unmapped_1c got=%h want=0", {key_held, key_press, key_release, any_press});
      end
      tick(1'b1, 8'h4D);
      total++;
      if (key_press !== 8'h80) begin bad++; $display("FAIL after_unmapped_idle got=%h want=80", key_press); end
   endtask

   task automatic test_timeout();
      do_reset();
      tick(1'b1, 8'hE0);
      repeat (PT) tick(1'b0, 8'h00);
      tick(1'b1, 8'h6B);
      total++;
      if (key_press !== 8'h00 || key_held !== 8'h00) begin
         bad++; $display("FAIL timeout_drop press=%h held=%h want 00/00", key_press, key_held);
      end
      tick(1'b1, 8'hE0);
      repeat (PT - 1) tick(1'b0, 8'h00);
      tick(1'b1, 8'h6B);
      total++;
      if (key_press !== 8'h04) begin bad++; $display("FAIL timeout_edge_keep got=%h want=04", key_press); end
      rst = 1'b1;
      tick(1'b0, 8'h00);
      total++;
      if (key_release !== 8'h00 || key_held !== 8'h00) begin
         bad++; $display("FAIL reset_no_release rel=%h held=%h want 00/00", key_release, key_held);
      end
      rst = 1'b0;
      tick(1'b1, 8'hE0);
      rst = 1'b1; tick(1'b0, 8'h00);
      rst = 1'b0; tick(1'b1, 8'h6B);
      total++;
      if (key_press !== 8'h00) begin bad++; $display("FAIL reset_mid_prefix got=%h want=00", key_press); end
   endtask

   task automatic test_overlap_error();
      do_reset();
      tick(1'b1, 8'hE0); tick(1'b1, 8'h6B);
      tick(1'b1, 8'hE0); tick(1'b1, 8'h74);
      total++;
      if (key_held !== 8'h0C) begin bad++; $display("FAIL both_held got=%h want=0c", key_held); end
      tick(1'b1, 8'hE0); tick(1'b1, 8'hF0); tick(1'b1, 8'h74);
      total++;
      if (key_release !== 8'h08 || key_held !== 8'h04) begin
         bad++; $display("FAIL release_right rel=%h held=%h want 08/04", key_release, key_held);
      end
      tick(1'b1, 8'hE0); tick(1'b1, 8'hF0); tick(1'b1, 8'hF0); tick(1'b1, 8'h6B);
      total++;
      if (key_release !== 8'h00 || key_held !== 8'h04) begin
         bad++; $display("FAIL brk_brk_error rel=%h held=%h want 00/04", key_release, key_held);
      end
      tick(1'b1, 8'hE0); tick(1'b1, 8'hF0); tick(1'b1, 8'h6B);
      tick(1'b1, 8'hE0); tick(1'b1, 8'hE0);
      total++;
      if (key_press !== 8'h00 || key_release !== 8'h00) begin
         bad++; $display("FAIL ext_ext_quiet press=%h rel=%h want 00/00", key_press, key_release);
      end
      tick(1'b1, 8'h6B);
      total++;
      if (key_press !== 8'h00 || key_held !== 8'h00) begin
         bad++; $display("FAIL ext_ext_idle press=%h held=%h want 00/00", key_press, key_held);
      end
   endtask

`ifdef KEY_AUTOREPEAT_EN
   task automatic test_autorepeat();
      bit exp_p;
      int extra;
      do_reset();
      tick(1'b1, 8'hE0);
      for (int off = 1; off <= 170; off++) begin
         if (off == 1) tick(1'b1, 8'h72);
         else tick(1'b0, 8'h00);
         exp_p = (off == 1) || (off == 101) || (off == 121) || (off == 141) || (off == 161);
         total++;
         if (key_press[CH_DOWN] !== exp_p) begin
            bad++; $display("FAIL repeat_pulse off=%0d got=%b want=%b", off, key_press[CH_DOWN], exp_p);
         end
      end
      tick(1'b1, 8'hE0); tick(1'b1, 8'hF0); tick(1'b1, 8'h72);
      total++;
      if (key_release !== 8'h10 || key_held !== 8'h00) begin
         bad++; $display("FAIL repeat_release rel=%h held=%h want 10/00", key_release, key_held);
      end
      extra = 0;
      repeat (100) begin tick(1'b0, 8'h00); extra += int'(any_press); end
      total++;
      if (extra != 0) begin bad++; $display("FAIL repeat_cancel pulses=%0d want=0", extra); end
   endtask
`else
   task automatic test_no_repeat();
      int np;
      do_reset();
      np = 0;
      tick(1'b1, 8'hE0);
      tick(1'b1, 8'h72); np += int'(key_press[CH_DOWN]);
      repeat (170) begin tick(1'b0, 8'h00); np += int'(key_press[CH_DOWN]); end
      total++;
      if (np != 1 || key_held !== 8'h10) begin
         bad++; $display("FAIL no_repeat presses=%0d held=%h want 1/10", np, key_held);
      end
   endtask
`endif

   task automatic test_random();
      int gap;
      logic [7:0] b;
      logic v;
      rst = 1'b1; tick(1'b0, 8'h00); rst = 1'b0;
      for (int n = 0; n < 500; n++) begin
         gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(PT - 2, PT + 1)) : int'($urandom_range(0, 2));
         b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
         rst = ($urandom_range(0, 60) == 0);
         for (int k = 0; k <= gap; k++) begin
            v = (k == gap) || rst;
            tick(v, b);
            total++;
            if ({key_held, key_press, key_release, any_press} !==
                {exp_held, exp_press, exp_release, |exp_press}) begin
               bad++;
               $display("FAIL random n=%0d held=%h/%h press=%h/%h rel=%h/%h any=%b",
                        n, key_held, exp_held, key_press, exp_press, key_release, exp_release, any_press);
            end
         end
         rst = 1'b0;
      end
   endtask

   initial begin
      @(negedge clk_50m);
      test_reset();
      test_make_break();
      test_typematic();
      test_unmapped();
      test_timeout();
      test_overlap_error();
`ifdef KEY_AUTOREPEAT_EN
      test_autorepeat();
`else
      test_no_repeat();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
